// File: rtl/act_pkg.sv
// Shared constants for the activation quantize/pack stage.
// - OUT_BITS / PACK_N : lane width and lanes per output word
// - PTR_W             : width of the lane pointer
// - UNS_MAX / SGN_*   : clamp limits for the ReLU and signed modes
package act_pkg;
  localparam int OUT_BITS  = 8;
  localparam int PACK_N    = 4;
  localparam int PTR_W     = $clog2(PACK_N);
  localparam int WORD_BITS = OUT_BITS * PACK_N;
  localparam int UNS_MAX   = (1 << OUT_BITS) - 1;
  localparam int SGN_MAX   = (1 << (OUT_BITS - 1)) - 1;
  localparam int SGN_MIN   = -(1 << (OUT_BITS - 1));
  localparam logic [15:0] SAT_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/act_sat_lane.sv
// Combinational ReLU + clamp of one shifted activation.
// Ports:
//   x   : signed DATA_BITS activation
//   q   : quantized OUT_BITS lane value
//   sat : 1 when the value was clamped at a saturating limit
module act_sat_lane
  import act_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic signed [DATA_BITS-1:0] x,
  output logic        [OUT_BITS-1:0]  q,
  output logic                        sat
);

  // ReLU mode is an unsigned clamp whose low limit is 0; hitting that
  // low limit is ordinary ReLU behaviour, not a saturation event.
  localparam logic signed [DATA_BITS-1:0] HI =
    RELU_EN ? DATA_BITS'(UNS_MAX) : DATA_BITS'(SGN_MAX);
  localparam logic signed [DATA_BITS-1:0] LO =
    RELU_EN ? DATA_BITS'(0) : DATA_BITS'(SGN_MIN);

  always_comb begin
    q   = x[OUT_BITS-1:0];
    sat = 1'b0;
    if (x > HI) begin
      q   = HI[OUT_BITS-1:0];
      sat = 1'b1;
    end else if (x < LO) begin
      q   = LO[OUT_BITS-1:0];
      sat = (RELU_EN == 1'b0);
    end
  end

endmodule

// File: rtl/act_quant_packer.sv
// Quantizes shifted activations to OUT_BITS lanes and packs PACK_N lanes
// per output word for the activation write-back buffer.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input beat stream, s_last flushes a word
//   m_valid/m_ready/m_data/m_keep/m_last : packed output word stream
//   clr_stat                  : clears the saturation counter
//   sat_cnt                   : saturating count of clamp events
// Handshake: a transfer happens on a side when valid && ready at the clock
// edge; a valid output word and its data/keep/last stay stable until taken.
module act_quant_packer
  import act_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter bit RELU_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WORD_BITS-1:0] m_data,
  output logic [PACK_N-1:0]    m_keep,
  output logic                 m_last,
  input  logic                 clr_stat,
  output logic [15:0]          sat_cnt
);

  logic [OUT_BITS-1:0]  lane_val;
  logic                 lane_sat;

  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WORD_BITS-1:0] pack_q, pack_d;
  logic                 m_valid_q, m_valid_d;
  logic [WORD_BITS-1:0] m_data_q, m_data_d;
  logic [PACK_N-1:0]    m_keep_q, m_keep_d;
  logic                 m_last_q, m_last_d;
  logic [15:0]          sat_cnt_q, sat_cnt_d;

  logic                 accept;
  logic                 complete;
  logic [WORD_BITS-1:0] word_w;
  logic [PACK_N-1:0]    keep_w;

  act_sat_lane #(
    .DATA_BITS (DATA_BITS),
    .RELU_EN   (RELU_EN)
  ) u_sat_lane (
    .x   (s_data),
    .q   (lane_val),
    .sat (lane_sat)
  );

  // Input is blocked only while a finished word is waiting downstream;
  // a pop in the same cycle frees the register for the next completion.
  assign s_ready  = !(m_valid_q && !m_ready);
  assign accept   = s_valid && s_ready;
  assign complete = accept && ((ptr_q == PTR_W'(PACK_N - 1)) || s_last);

  always_comb begin
    // Word as it looks with the current beat merged into its lane.
    word_w = pack_q;
    word_w[int'(ptr_q) * OUT_BITS +: OUT_BITS] = lane_val;
    // Lanes 0..ptr are filled once the current beat lands.
    for (int i = 0; i < PACK_N; i++) begin
      keep_w[i] = (PTR_W'(i) <= ptr_q);
    end

    ptr_d     = ptr_q;
    pack_d    = pack_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (complete) begin
      m_valid_d = 1'b1;
      m_data_d  = word_w;
      m_keep_d  = keep_w;
      m_last_d  = s_last;
      ptr_d     = '0;
      pack_d    = '0;
    end else if (accept) begin
      pack_d = word_w;
      ptr_d  = ptr_q + 1'b1;
    end

    sat_cnt_d = sat_cnt_q;
    if (clr_stat) begin
      sat_cnt_d = '0;
    end else if (accept && lane_sat && (sat_cnt_q != SAT_CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      pack_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pack_q    <= pack_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_act_quant_packer.sv
// Bench for act_quant_packer: one ReLU instance and one signed-clamp
// instance share every input, so one stimulus stream covers both modes.
module tb_act_quant_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_valid, s_last, m_ready, clr_stat;
  logic [31:0] s_data;

  logic        s_ready_r, m_valid_r, m_last_r;
  logic [31:0] m_data_r;
  logic [3:0]  m_keep_r;
  logic [15:0] sat_cnt_r;

  logic        s_ready_s, m_valid_s, m_last_s;
  logic [31:0] m_data_s;
  logic [3:0]  m_keep_s;
  logic [15:0] sat_cnt_s;

  act_quant_packer #(.DATA_BITS(32), .RELU_EN(1'b1)) dut_r (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_r),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_r), .m_ready(m_ready),
    .m_data(m_data_r), .m_keep(m_keep_r), .m_last(m_last_r),
    .clr_stat(clr_stat), .sat_cnt(sat_cnt_r)
  );

  act_quant_packer #(.DATA_BITS(32), .RELU_EN(1'b0)) dut_s (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_s),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid_s), .m_ready(m_ready),
    .m_data(m_data_s), .m_keep(m_keep_s), .m_last(m_last_s),
    .clr_stat(clr_stat), .sat_cnt(sat_cnt_s)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct packed {
    logic [31:0] dr;    // word expected from the ReLU instance
    logic [31:0] ds;    // word expected from the signed instance
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t       exp_q[$];     // words sitting in the output register (0 or 1)
  word_t       hold;         // what the output shows while no word is valid
  logic [7:0]  lanes_r[$];
  logic [7:0]  lanes_s[$];
  int          sat_r, sat_s;
  bit          acc;
  int          cyc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void quant(input int x, input bit relu, output logic [7:0] q, output bit sat);
    int v;
    v   = x;
    sat = 1'b0;
    if (relu) begin
      if (x < 0) v = 0;
      else if (x > 255) begin v = 255; sat = 1'b1; end
    end else begin
      if (x > 127) begin v = 127; sat = 1'b1; end
      else if (x < -128) begin v = -128; sat = 1'b1; end
    end
    q = v[7:0];
  endfunction

  function automatic logic [31:0] pack_lanes(input logic [7:0] l[$]);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < l.size(); i++) w = w | (32'(l[i]) << (8 * i));
    return w;
  endfunction

  // One clock: model acts on the inputs present at the edge, then the
  // registered outputs are compared just after the edge.
  task automatic tick();
    logic       exp_rdy;
    logic [7:0] qr, qs;
    bit         sr, ss;
    word_t      cur, nw;
    @(negedge clk);
    exp_rdy = !((exp_q.size() != 0) && !m_ready);
    check("s_ready_r", s_ready_r, exp_rdy);
    check("s_ready_s", s_ready_s, exp_rdy);
    acc = 1'b0;
    if (rst) begin
      exp_q.delete(); lanes_r.delete(); lanes_s.delete();
      sat_r = 0; sat_s = 0; hold = '0;
    end else begin
      if ((exp_q.size() != 0) && m_ready) hold = exp_q.pop_front();
      acc = s_valid && exp_rdy;
      if (acc) begin
        quant(int'($signed(s_data)), 1'b1, qr, sr);
        quant(int'($signed(s_data)), 1'b0, qs, ss);
        lanes_r.push_back(qr);
        lanes_s.push_back(qs);
        if (sr && sat_r < 65535) sat_r++;
        if (ss && sat_s < 65535) sat_s++;
        if (lanes_r.size() == act_pkg::PACK_N || s_last) begin
          nw.dr   = pack_lanes(lanes_r);
          nw.ds   = pack_lanes(lanes_s);
          nw.keep = 4'((1 << lanes_r.size()) - 1);
          nw.last = s_last;
          exp_q.push_back(nw);
          lanes_r.delete(); lanes_s.delete();
        end
      end
      if (clr_stat) begin sat_r = 0; sat_s = 0; end
    end
    @(posedge clk); #1;
    cyc++;
    cur = (exp_q.size() != 0) ? exp_q[0] : hold;
    check("m_valid_r", m_valid_r, exp_q.size() != 0);
    check("m_valid_s", m_valid_s, exp_q.size() != 0);
    check("m_data_r",  m_data_r,  cur.dr);
    check("m_data_s",  m_data_s,  cur.ds);
    check("m_keep_r",  m_keep_r,  cur.keep);
    check("m_keep_s",  m_keep_s,  cur.keep);
    check("m_last_r",  m_last_r,  cur.last);
    check("m_last_s",  m_last_s,  cur.last);
    check("sat_cnt_r", sat_cnt_r, 16'(sat_r));
    check("sat_cnt_s", sat_cnt_s, 16'(sat_s));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int x, input bit last);
    s_valid = 1'b1;
    s_data  = 32'(x);
    s_last  = last;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (acc) break;
    end
    if (!acc) check("beat_timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    clr_stat = 1'b1;
    idle(1);
    clr_stat = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int edge_vals[10];
    edge_vals = '{127, 128, -128, -129, 255, 256, 0, -1, 32'h7fffffff, 32'h80000000};
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1; clr_stat = 1'b0; cyc = 0;
    sat_r = 0; sat_s = 0; hold = '0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // ReLU word with a negative, an over-range and an exact-max value.
    send_beat(5, 0); send_beat(-3, 0); send_beat(300, 0); send_beat(255, 0);
    check("t1_data", m_data_r, 32'hFFFF_0005);
    check("t1_keep", m_keep_r, 4'hF);
    check("t1_sat",  sat_cnt_r, 16'd1);
    idle(1);

    // Signed clamp at both ends plus the exact limits.
    clear_stats();
    send_beat(200, 0); send_beat(-200, 0); send_beat(127, 0); send_beat(-128, 0);
    check("t2_data", m_data_s, 32'h807F_807F);
    check("t2_sat",  sat_cnt_s, 16'd2);
    idle(1);

    // Short row flushed by s_last, then a fresh word from lane 0.
    send_beat(1, 0); send_beat(2, 1);
    check("t3_data", m_data_r, 32'h0000_0201);
    check("t3_keep", m_keep_r, 4'b0011);
    check("t3_last", m_last_r, 1'b1);
    send_beat(7, 1);
    check("t3_next", m_data_r, 32'h0000_0007);
    idle(1);

    // Backpressure: a held word blocks four offered beats, nothing is lost.
    m_ready = 1'b0;
    send_beat(10, 0); send_beat(20, 0); send_beat(30, 0); send_beat(40, 0);
    s_valid = 1'b1; s_data = 32'd50; s_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_blocked", s_ready_r, 1'b0);
    end
    m_ready = 1'b1;
    send_beat(50, 0); send_beat(60, 0); send_beat(70, 0); send_beat(80, 0);
    idle(2);

    // Full-rate burst: 16 beats in 16 cycles.
    t0 = cyc;
    for (int i = 0; i < 16; i++) send_beat(i * 17 - 40, 0);
    check("t5_cycles", cyc - t0, 16);
    idle(2);

    // Reset in the middle of a word, then clear coincident with a sat beat.
    send_beat(3, 0); send_beat(4, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_rst_valid", m_valid_r, 1'b0);
    check("t6_rst_data",  m_data_r,  32'h0);
    send_beat(9, 1);
    check("t6_lane0", m_data_r, 32'h0000_0009);
    check("t6_keep",  m_keep_r, 4'b0001);
    clr_stat = 1'b1;
    send_beat(300, 1);
    clr_stat = 1'b0;
    check("t6_clr", sat_cnt_r, 16'd0);
    idle(1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 600; n++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      s_last   = ($urandom_range(0, 7) == 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      clr_stat = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0: s_data = 32'(int'($urandom_range(0, 600)) - 300);
        1: s_data = $urandom();
        2: s_data = 32'($urandom_range(0, 255));
        default: s_data = 32'(edge_vals[$urandom_range(0, 9)]);
      endcase
      tick();
    end
    s_valid = 1'b0; clr_stat = 1'b0; m_ready = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
